// File: rtl/seg7_scan_if.sv
// Display-side bundle for the multiplexed 7-segment scan driver.
// The master owns the content and mask inputs. The slave (the driver) owns the pin outputs.
interface seg7_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      enable;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_start;

    modport master (
        output enable, digits_in, blank_mask, blink_mask,
        input  seg, an, frame_start
    );

    modport slave (
        input  enable, digits_in, blank_mask, blink_mask,
        output seg, an, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with a refresh prescaler and a per-frame snapshot.
// It also provides per-digit blank and blink, and selectable output polarity.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    seg7_scan_if.slave bus
);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PreW = $clog2(REFRESH_DIV);
    localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PreW-1:0]       PreLast = PreW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0]       IdxLast = IdxW'(NUM_DIGITS - 1);
    localparam logic [FrmW-1:0]       FrmLast = FrmW'(BLINK_FRAMES - 1);
    localparam logic [6:0]            SegOff  = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AnOff   = {NUM_DIGITS{ACTIVE_LOW}};

    logic [PreW-1:0]         r_presc;
    logic [IdxW-1:0]         r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [FrmW-1:0]         r_frame_cnt;
    logic                    r_blink_phase;
    logic                    r_frame_start;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_tick;
    logic                    w_wrap;
    logic [3:0]              w_code;
    logic                    w_dark;
    logic [6:0]              w_pattern;
    logic [NUM_DIGITS-1:0]   w_an_hot;

    // Active-high glyph pattern. Bit order is {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'h0:    pat = 7'b0111111;
            4'h1:    pat = 7'b0000110;
            4'h2:    pat = 7'b1011011;
            4'h3:    pat = 7'b1001111;
            4'h4:    pat = 7'b1100110;
            4'h5:    pat = 7'b1101101;
            4'h6:    pat = 7'b1111101;
            4'h7:    pat = 7'b0000111;
            4'h8:    pat = 7'b1111111;
            4'h9:    pat = 7'b1101111;
            4'hA:    pat = 7'b1110001;
            4'hB:    pat = 7'b0111110;
            4'hC:    pat = 7'b0111001;
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

    assign w_tick = (r_presc == PreLast);
    assign w_wrap = w_tick && (r_idx == IdxLast);

    always_comb begin
        w_code    = r_shadow[{r_idx, 2'b00} +: 4];
        // Masks are sampled live, so blanking reacts within one cycle and does not wait for a frame.
        w_dark    = bus.blank_mask[r_idx] | (bus.blink_mask[r_idx] & r_blink_phase);
        w_pattern = w_dark ? 7'b0000000 : glyph(w_code);
        w_an_hot  = '0;
        w_an_hot[r_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_frame_start <= 1'b0;
            r_seg         <= SegOff;
            r_an          <= AnOff;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IdxLast) ? '0 : r_idx + 1'b1;
            end
            r_frame_start <= w_wrap;
            if (w_wrap) begin
                r_shadow <= bus.digits_in;
                if (r_frame_cnt == FrmLast) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
            // The scan keeps running while disabled; only the pins are forced inactive.
            if (bus.enable) begin
                r_seg <= w_pattern ^ SegOff;
                r_an  <= w_an_hot ^ AnOff;
            end else begin
                r_seg <= SegOff;
                r_an  <= AnOff;
            end
        end
    end

    assign bus.seg         = r_seg;
    assign bus.an          = r_an;
    assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2, active-low.
// Each task queues the expected pin state per cycle, then compares it cycle by cycle.
module tb_seg7_scan_driver;
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    seg7_scan_if #(.NUM_DIGITS(4)) u_if ();

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLINK_FRAMES(2),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The glyph table is written active-high and inverted here to give active-low pin values.
    function automatic logic [6:0] gl(input int code);
        logic [6:0] p;
        case (code)
            0:  p = 7'b0111111;
            1:  p = 7'b0000110;
            3:  p = 7'b1001111;
            9:  p = 7'b1101111;
            10: p = 7'b1110001;
            11: p = 7'b0111110;
            12: p = 7'b0111001;
            default: p = 7'b0000000;
        endcase
        return ~p;
    endfunction

    function automatic void push_one(input logic [3:0] an, input logic [6:0] seg, input logic fs);
        exp_t e;
        e.an  = an;
        e.seg = seg;
        e.fs  = fs;
        sb.push_back(e);
    endfunction

    function automatic void push_digit(input int k, input logic [6:0] seg, input logic fs_last);
        logic [3:0] an;
        an = ~(4'b0001 << k);
        for (int i = 0; i < 4; i++) push_one(an, seg, fs_last && (i == 3));
    endfunction

    function automatic void push_frame(input logic [6:0] s0, input logic [6:0] s1,
                                       input logic [6:0] s2, input logic [6:0] s3);
        push_digit(0, s0, 1'b0);
        push_digit(1, s1, 1'b0);
        push_digit(2, s2, 1'b0);
        push_digit(3, s3, 1'b1);
    endfunction

    // Advances to the cycle in which frame_start is sampled high. A missing pulse counts as a failure.
    task automatic wait_frame(input string who);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = (u_if.frame_start === 1'b1);
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s wait_frame: frame_start=%b after 40 cycles, required 1", who,
                     u_if.frame_start);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        u_if.enable = 1'b1;
        u_if.digits_in = 16'h0000;
        u_if.blank_mask = 4'b0000;
        u_if.blink_mask = 4'b0000;
        repeat (2) @(negedge clk);
        n_checks++;
        if (u_if.an !== 4'b1111) begin
            n_errors++;
            $display("FAIL reset_an: got %b, required 1111", u_if.an);
        end
        n_checks++;
        if (u_if.seg !== 7'b1111111) begin
            n_errors++;
            $display("FAIL reset_seg: got %b, required 1111111", u_if.seg);
        end
        n_checks++;
        if (u_if.frame_start !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_fs: got %b, required 0", u_if.frame_start);
        end
        rst = 1'b0;
        push_frame(gl(0), gl(0), gl(0), gl(0));
        push_digit(0, gl(0), 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            n_checks++;
            if ({u_if.an, u_if.seg, u_if.frame_start} !== e) begin
                n_errors++;
                $display("FAIL scan_order: an=%b seg=%b fs=%b, required an=%b seg=%b fs=%b",
                         u_if.an, u_if.seg, u_if.frame_start, e.an, e.seg, e.fs);
            end
        end
    endtask

    task automatic test_glyphs();
        exp_t e;
        u_if.digits_in = 16'hCBA9;
        wait_frame("glyphs");
        push_frame(gl(9), gl(10), gl(11), gl(12));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            n_checks++;
            if ({u_if.an, u_if.seg, u_if.frame_start} !== e) begin
                n_errors++;
                $display("FAIL glyphs: an=%b seg=%b fs=%b, required an=%b seg=%b fs=%b",
                         u_if.an, u_if.seg, u_if.frame_start, e.an, e.seg, e.fs);
            end
        end
    endtask

    task automatic test_no_tear();
        exp_t e;
        wait_frame("no_tear");
        push_digit(0, gl(9), 1'b0);
        push_digit(1, gl(10), 1'b0);
        for (int phase = 0; phase < 2; phase++) begin
            while (sb.size() > 0) begin
                e = sb.pop_front();
                @(posedge clk);
                #1;
                n_checks++;
                if ({u_if.an, u_if.seg, u_if.frame_start} !== e) begin
                    n_errors++;
                    $display("FAIL no_tear[%0d]: an=%b seg=%b fs=%b, required an=%b seg=%b fs=%b",
                             phase, u_if.an, u_if.seg, u_if.frame_start, e.an, e.seg, e.fs);
                end
            end
            if (phase == 0) begin
                // The scan is now on digit 2. The new code must wait for the next snapshot.
                u_if.digits_in = 16'h1111;
                push_digit(2, gl(11), 1'b0);
                push_digit(3, gl(12), 1'b1);
                push_frame(gl(1), gl(1), gl(1), gl(1));
            end
        end
    endtask

    task automatic test_blink();
        exp_t e;
        #3;
        rst = 1'b1;
        u_if.digits_in = 16'h1111;
        u_if.blink_mask = 4'b0001;
        @(negedge clk);
        rst = 1'b0;
        wait_frame("blink");
        push_frame(gl(1), gl(1), gl(1), gl(1));
        push_frame(7'h7F, gl(1), gl(1), gl(1));
        push_frame(7'h7F, gl(1), gl(1), gl(1));
        push_frame(gl(1), gl(1), gl(1), gl(1));
        for (int phase = 0; phase < 2; phase++) begin
            while (sb.size() > 0) begin
                e = sb.pop_front();
                @(posedge clk);
                #1;
                n_checks++;
                if ({u_if.an, u_if.seg, u_if.frame_start} !== e) begin
                    n_errors++;
                    $display("FAIL blink[%0d]: an=%b seg=%b fs=%b, required an=%b seg=%b fs=%b",
                             phase, u_if.an, u_if.seg, u_if.frame_start, e.an, e.seg, e.fs);
                end
            end
            if (phase == 0) begin
                u_if.blank_mask = 4'b0001;
                push_frame(7'h7F, gl(1), gl(1), gl(1));
                push_frame(7'h7F, gl(1), gl(1), gl(1));
            end
        end
        u_if.blank_mask = 4'b0000;
        u_if.blink_mask = 4'b0000;
    endtask

    task automatic test_enable();
        exp_t e;
        wait_frame("enable");
        u_if.enable = 1'b0;
        for (int i = 0; i < 10; i++) push_one(4'b1111, 7'h7F, 1'b0);
        for (int phase = 0; phase < 2; phase++) begin
            while (sb.size() > 0) begin
                e = sb.pop_front();
                @(posedge clk);
                #1;
                n_checks++;
                if ({u_if.an, u_if.seg, u_if.frame_start} !== e) begin
                    n_errors++;
                    $display("FAIL enable[%0d]: an=%b seg=%b fs=%b, required an=%b seg=%b fs=%b",
                             phase, u_if.an, u_if.seg, u_if.frame_start, e.an, e.seg, e.fs);
                end
            end
            if (phase == 0) begin
                // The scan kept counting through the 10 disabled cycles, so it resumes partway through digit 2.
                u_if.enable = 1'b1;
                push_one(4'b1011, gl(1), 1'b0);
                push_one(4'b1011, gl(1), 1'b0);
                push_digit(3, gl(1), 1'b1);
            end
        end
    endtask

    task automatic test_blank_codes();
        exp_t e;
        u_if.digits_in = 16'hFED3;
        wait_frame("blank_codes");
        push_frame(gl(3), gl(13), gl(14), gl(15));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            n_checks++;
            if ({u_if.an, u_if.seg, u_if.frame_start} !== e) begin
                n_errors++;
                $display("FAIL blank_codes: an=%b seg=%b fs=%b, required an=%b seg=%b fs=%b",
                         u_if.an, u_if.seg, u_if.frame_start, e.an, e.seg, e.fs);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        wait_frame("async_reset");
        repeat (6) @(posedge clk);
        #3;
        n_checks++;
        if (u_if.an !== 4'b1101) begin
            n_errors++;
            $display("FAIL pre_reset_an: got %b, required 1101", u_if.an);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (u_if.an !== 4'b1111) begin
            n_errors++;
            $display("FAIL async_an: got %b, required 1111", u_if.an);
        end
        n_checks++;
        if (u_if.seg !== 7'b1111111) begin
            n_errors++;
            $display("FAIL async_seg: got %b, required 1111111", u_if.seg);
        end
        @(negedge clk);
        rst = 1'b0;
        // The snapshot was cleared, so the scan restarts at digit 0 and shows "0" even though the input is FED3.
        push_frame(gl(0), gl(0), gl(0), gl(0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            n_checks++;
            if ({u_if.an, u_if.seg, u_if.frame_start} !== e) begin
                n_errors++;
                $display("FAIL post_reset: an=%b seg=%b fs=%b, required an=%b seg=%b fs=%b",
                         u_if.an, u_if.seg, u_if.frame_start, e.an, e.seg, e.fs);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_glyphs();
        test_no_tear();
        test_blink();
        test_enable();
        test_blank_codes();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
